// File: rtl/lane_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : lane_arbiter
//  Description : Round-robin arbiter and link sequencer. Shares one byte-wide
//                serializer input among four FWFT byte FIFOs. After enable it
//                runs the link bring-up sequence IDLE -> SYNC -> ACTIVE. Every
//                cycle that carries no data is filled with IDLE_SYMBOL.
//  Revision    : 1.0 - initial release
// ============================================================================
module lane_arbiter #(
  parameter int                   DATA_WIDTH  = 8,
  parameter int                   SYNC_CYCLES = 4,
  parameter logic [DATA_WIDTH-1:0] IDLE_SYMBOL = 8'hBC
) (
  input  logic                    clk_4f,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    pause,
  input  logic [3:0]              fifo_empty,
  input  logic [4*DATA_WIDTH-1:0] fifo_data,
  output logic [3:0]              pop,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    valid_out,
  output logic [1:0]              grant_id,
  output logic                    link_up
);

  // Link bring-up states; ACTIVE is the only state in which bytes are granted.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  localparam logic [7:0] SYNC_LAST = 8'(SYNC_CYCLES - 1);

  state_t                  state;
  logic [1:0]              rr_ptr;
  logic [7:0]              sync_cnt;

  logic [DATA_WIDTH-1:0]   lane_data [4];
  logic                    any_ready;
  logic [1:0]              winner;
  logic                    grant;

  // Split the packed head-word bus into one byte per requester.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_data[gi] = fifo_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Find the first non-empty requester starting at rr_ptr; walking the offsets
  // from the far end back lets the nearest candidate overwrite the others.
  always_comb begin
    any_ready = 1'b0;
    winner    = rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (!fifo_empty[rr_ptr + 2'(k)]) begin
        any_ready = 1'b1;
        winner    = rr_ptr + 2'(k);
      end
    end
  end

  // A grant needs the link up, enable still high and no downstream back-pressure.
  assign grant = (state == ST_ACTIVE) && enable && !pause && any_ready;

  // One-hot read strobe to the winning FIFO; never to an empty one.
  always_comb begin
    pop = 4'b0000;
    if (grant) begin
      pop[winner] = 1'b1;
    end
  end

  // Sequencer, round-robin pointer and registered serializer outputs.
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      rr_ptr    <= 2'd0;
      sync_cnt  <= 8'd0;
      data_out  <= IDLE_SYMBOL;
      valid_out <= 1'b0;
      grant_id  <= 2'd0;
      link_up   <= 1'b0;
    end else if (!enable) begin
      // Dropping enable tears the link down but keeps the fairness pointer.
      state     <= ST_IDLE;
      sync_cnt  <= 8'd0;
      data_out  <= IDLE_SYMBOL;
      valid_out <= 1'b0;
      grant_id  <= 2'd0;
      link_up   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state     <= ST_SYNC;
          sync_cnt  <= 8'd0;
          data_out  <= IDLE_SYMBOL;
          valid_out <= 1'b0;
          grant_id  <= 2'd0;
          link_up   <= 1'b0;
        end
        ST_SYNC: begin
          data_out  <= IDLE_SYMBOL;
          valid_out <= 1'b0;
          grant_id  <= 2'd0;
          if (sync_cnt == SYNC_LAST) begin
            state   <= ST_ACTIVE;
            link_up <= 1'b1;
          end else begin
            sync_cnt <= sync_cnt + 8'd1;
            link_up  <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          link_up <= 1'b1;
          if (grant) begin
            data_out  <= lane_data[winner];
            valid_out <= 1'b1;
            grant_id  <= winner;
            rr_ptr    <= winner + 2'd1;
          end else begin
            data_out  <= IDLE_SYMBOL;
            valid_out <= 1'b0;
            grant_id  <= 2'd0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          data_out  <= IDLE_SYMBOL;
          valid_out <= 1'b0;
          grant_id  <= 2'd0;
          link_up   <= 1'b0;
        end
      endcase
    end
  end

  // Structural guarantees of the read strobe.
  a_pop_onehot: assert property (@(posedge clk_4f) disable iff (!reset)
    $onehot0(pop));
  a_pop_not_empty: assert property (@(posedge clk_4f) disable iff (!reset)
    (pop & fifo_empty) == 4'b0000);

endmodule
`default_nettype wire
